// File: rtl/xy_follow_responder_pkg.sv
// Shared types and limits for the x_sig -> y_sig follow responder.
package xy_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam int LATENCY_MAX  = 16;
  localparam int MAX_PEND_MAX = 255;

  // Width needed to hold a backlog count of 0..max_pend.
  function automatic int pw_f(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/xy_follow_responder_if.sv
// Request/response signal bundle between a request source and the responder.
interface xy_follow_responder_if #(
  parameter int PW = 4
);
  logic          en;
  logic          x_sig;
  logic          stall;
  logic          ovf_clr;
  logic          y_sig;
  logic [PW-1:0] pend_cnt;
  logic          overflow;
  logic          busy;

  modport master (
    output en, x_sig, stall, ovf_clr,
    input  y_sig, pend_cnt, overflow, busy
  );

  modport slave (
    input  en, x_sig, stall, ovf_clr,
    output y_sig, pend_cnt, overflow, busy
  );
endinterface

// File: rtl/xy_delay_line.sv
// Fixed-depth 1-bit shift register; a plain wire when DEPTH is 0.
module xy_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic occupied
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst_n;
    assign dout      = din;
    assign occupied  = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0] stage_p;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_p <= '0;
      end else begin
        stage_p[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_p[i] <= stage_p[i-1];
        end
      end
    end

    assign dout     = stage_p[DEPTH-1];
    assign occupied = |stage_p;
  end

endmodule

// File: rtl/xy_follow_responder.sv
// Follow-protocol responder: one y_sig pulse per accepted x_sig request,
// LATENCY clocks later, with a bounded backlog while downstream stalls.
module xy_follow_responder
  import xy_resp_pkg::*;
#(
  parameter int LATENCY  = 1,
  parameter int MAX_PEND = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  xy_follow_responder_if.slave bus
);

  localparam int PW = pw_f(MAX_PEND);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "xy_follow_responder: LATENCY %0d outside 1..%0d", LATENCY, LATENCY_MAX);
  end
  if (MAX_PEND < 1 || MAX_PEND > MAX_PEND_MAX) begin : g_bad_max_pend
    $fatal(1, "xy_follow_responder: MAX_PEND %0d outside 1..%0d", MAX_PEND, MAX_PEND_MAX);
  end

  logic          accept;
  logic          arrival;
  logic          issue;
  logic          line_occ;
  logic          ovf_set;
  logic [PW-1:0] pend_nxt;
  state_t        state, state_nxt;

  assign accept = bus.x_sig & bus.en;

  xy_delay_line #(
    .DEPTH (LATENCY - 1)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (accept),
    .dout     (arrival),
    .occupied (line_occ)
  );

  // A matured response either issues now or joins the backlog; at a full
  // backlog a stalled arrival is dropped instead.
  assign issue   = (arrival | (bus.pend_cnt != '0)) & ~bus.stall;
  assign ovf_set = arrival & ~issue & (bus.pend_cnt == PW'(MAX_PEND));

  always_comb begin
    pend_nxt = bus.pend_cnt;
    if (!ovf_set) begin
      pend_nxt = bus.pend_cnt + PW'(arrival) - PW'(issue);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_sig    <= 1'b0;
      bus.pend_cnt <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.y_sig    <= issue;
      bus.pend_cnt <= pend_nxt;
      bus.overflow <= ovf_set | (bus.overflow & ~bus.ovf_clr);
    end
  end

  assign bus.busy = line_occ | (bus.pend_cnt != '0) | bus.y_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Activity tracker; mirrors busy and never feeds back into the datapath.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.stall && ((bus.pend_cnt != '0) || arrival)) state_nxt = HOLD;
        else if (!bus.busy && !accept)                      state_nxt = IDLE;
      end
      HOLD:    if (!bus.stall) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xy_follow_responder.sv
// Randomized bench for xy_follow_responder: three parameterisations driven in
// lockstep and compared each cycle against a timestamp/backlog reference model.
module tb_xy_follow_responder;
  import xy_resp_pkg::*;

  localparam int N = 3;
  localparam int LAT [N] = '{1, 3, 2};
  localparam int MP  [N] = '{4, 8, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xy_follow_responder_if #(.PW(pw_f(4))) if0 ();
  xy_follow_responder_if #(.PW(pw_f(8))) if1 ();
  xy_follow_responder_if #(.PW(pw_f(1))) if2 ();

  xy_follow_responder #(.LATENCY(1), .MAX_PEND(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  xy_follow_responder #(.LATENCY(3), .MAX_PEND(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  xy_follow_responder #(.LATENCY(2), .MAX_PEND(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic       y_o    [N];
  logic [7:0] pend_o [N];
  logic       ovf_o  [N];
  logic       busy_o [N];

  assign y_o[0] = if0.y_sig;  assign pend_o[0] = 8'(if0.pend_cnt);
  assign y_o[1] = if1.y_sig;  assign pend_o[1] = 8'(if1.pend_cnt);
  assign y_o[2] = if2.y_sig;  assign pend_o[2] = 8'(if2.pend_cnt);
  assign ovf_o[0] = if0.overflow;  assign busy_o[0] = if0.busy;
  assign ovf_o[1] = if1.overflow;  assign busy_o[1] = if1.busy;
  assign ovf_o[2] = if2.overflow;  assign busy_o[2] = if2.busy;

  // With LATENCY=1, an unstalled request on an empty backlog answers next clock.
  a_follow: assert property (@(posedge clk) disable iff (!rst_n)
    (if0.x_sig && if0.en && !if0.stall && if0.pend_cnt == '0) |=> if0.y_sig);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted request is a due-time stamp; the backlog
  // is a plain integer bounded by MAX_PEND.
  logic en_d, x_d, stall_d, clr_d;
  int   cyc;
  int   due_q  [N][$];
  int   pend_m [N];
  bit   ovf_m  [N];
  bit   y_m    [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      due_q[i].delete();
      pend_m[i] = 0;
      ovf_m[i]  = 1'b0;
      y_m[i]    = 1'b0;
    end
  endtask

  task automatic model_step();
    bit acc, arr, iss, drop;
    acc = x_d & en_d;
    for (int i = 0; i < N; i++) begin
      if (acc) due_q[i].push_back(cyc + LAT[i] - 1);
      arr = 1'b0;
      if (due_q[i].size() > 0 && due_q[i][0] == cyc) begin
        arr = 1'b1;
        void'(due_q[i].pop_front());
      end
      iss  = (arr || pend_m[i] > 0) && !stall_d;
      drop = arr && !iss && pend_m[i] == MP[i];
      if (!drop) pend_m[i] = pend_m[i] + int'(arr) - int'(iss);
      ovf_m[i] = drop ? 1'b1 : (clr_d ? 1'b0 : ovf_m[i]);
      y_m[i]   = iss;
    end
    cyc++;
  endtask

  task automatic check_all();
    bit busy_m;
    for (int i = 0; i < N; i++) begin
      busy_m = due_q[i].size() > 0 || pend_m[i] > 0 || y_m[i];
      chk($sformatf("y_sig[%0d]", i),    int'(y_o[i]),    int'(y_m[i]));
      chk($sformatf("pend_cnt[%0d]", i), int'(pend_o[i]), pend_m[i]);
      chk($sformatf("overflow[%0d]", i), int'(ovf_o[i]),  int'(ovf_m[i]));
      chk($sformatf("busy[%0d]", i),     int'(busy_o[i]), int'(busy_m));
    end
  endtask

  task automatic set_in(input logic e, input logic x, input logic s, input logic c);
    en_d = e; x_d = x; stall_d = s; clr_d = c;
    if0.en = e; if0.x_sig = x; if0.stall = s; if0.ovf_clr = c;
    if1.en = e; if1.x_sig = x; if1.stall = s; if1.ovf_clr = c;
    if2.en = e; if2.x_sig = x; if2.stall = s; if2.ovf_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int stall_run;
    cyc = 0;
    model_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Unconstrained traffic.
    for (int n = 0; n < 300; n++) begin
      set_in($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      step();
    end

    // Long stall with continuous requests: saturate, then clear while dropping.
    for (int n = 0; n < 12; n++) begin
      set_in(1'b1, 1'b1, 1'b1, n == 9);
      step();
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    for (int n = 0; n < 14; n++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end

    // Asynchronous reset with backlog and a full delay line.
    for (int n = 0; n < 6; n++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) step();

    // Bursty stall with dense requests.
    stall_run = 0;
    for (int n = 0; n < 400; n++) begin
      if (stall_run == 0) stall_run = $urandom_range(1, 12);
      stall_run--;
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
             (n / 10) % 3 == 1 && stall_run > 2, $urandom_range(0, 15) == 0);
      step();
    end

    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
